// File: rtl/imem_arbiter_if.sv
// Instruction-memory arbiter bundle: fetch, debug and memory-side signals.
// Latency: wires only; the arbiter owns all timing.
// Backpressure: grants are the only stall mechanism; requesters hold until granted.
// Ports: fetch (if_*), debug/loader (dbg_*), memory (mem_*), sticky err.
// Modports: slave = the arbiter, master = requesters plus memory model.
interface imem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_stall;
  logic        if_valid;
  logic [31:0] if_instr;

  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_valid;
  logic [31:0] dbg_rdata;

  logic        err;

  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    output if_gnt, if_stall, if_valid, if_instr,
    output dbg_gnt, dbg_valid, dbg_rdata, err,
    output mem_addr, mem_we, mem_wdata
  );

  modport master (
    output if_req, if_addr, dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
    input  if_gnt, if_stall, if_valid, if_instr,
    input  dbg_gnt, dbg_valid, dbg_rdata, err,
    input  mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares one instruction-memory port between IF fetches and the debug/loader port.
// Latency: grant is combinational in cycle N; valid/data are registered into cycle N+1.
// Backpressure: loser sees no grant and holds its request; if_stall flags denied fetches.
// Ports: clk, reset (sync, active-high), bus (imem_arbiter_if.slave).
// Option: define IMEM_ARB_STARVE_GUARD_EN to let a fetch win after MAX_WAIT
//         consecutive denials; otherwise debug has strict priority.
module imem_arbiter #(
  parameter int MEM_WORDS = 2048,
  parameter int MAX_WAIT  = 4
) (
  input  logic          clk,
  input  logic          reset,
  imem_arbiter_if.slave bus
);

  localparam logic [29:0] WORDS_LIM = 30'(MEM_WORDS);

  logic        if_gnt;
  logic        dbg_gnt;
  logic        any_gnt;
  logic        bad;
  logic        fetch_turn;
  logic [31:0] sel_addr;
  logic [31:0] rd_word;

  logic        if_valid_q,  if_valid_d;
  logic [31:0] if_instr_q,  if_instr_d;
  logic        dbg_valid_q, dbg_valid_d;
  logic [31:0] dbg_rdata_q, dbg_rdata_d;
  logic        err_q,       err_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

`ifdef IMEM_ARB_STARVE_GUARD_EN
  logic [3:0]  wait_cnt_q,  wait_cnt_d;

  // Fetch has been denied long enough that it takes the port from debug.
  assign fetch_turn = (wait_cnt_q == 4'(MAX_WAIT));
`else
  assign fetch_turn = 1'b0;
`endif

  always_comb begin
    dbg_gnt  = bus.dbg_req && !(bus.if_req && fetch_turn);
    if_gnt   = bus.if_req && !dbg_gnt;
    any_gnt  = dbg_gnt || if_gnt;
    sel_addr = dbg_gnt ? bus.dbg_addr : bus.if_addr;

    // Bad accesses are still granted and completed, but never write and read as zero.
    bad      = any_gnt && ((sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= WORDS_LIM));
    rd_word  = bad ? 32'h0 : bus.mem_rdata;

    // Memory address/data hold their last granted value on idle cycles.
    mem_addr_d  = any_gnt ? {sel_addr[31:2], 2'b00} : mem_addr_q;
    mem_wdata_d = dbg_gnt ? bus.dbg_wdata : mem_wdata_q;

    if_valid_d  = if_gnt;
    if_instr_d  = if_gnt ? rd_word : if_instr_q;
    dbg_valid_d = dbg_gnt;
    // Debug writes complete with a valid pulse but leave the read data untouched.
    dbg_rdata_d = (dbg_gnt && !bus.dbg_we) ? rd_word : dbg_rdata_q;
    err_d       = err_q || bad;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    if (!bus.if_req || if_gnt) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q < 4'(MAX_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid_q  <= 1'b0;
      if_instr_q  <= 32'h0;
      dbg_valid_q <= 1'b0;
      dbg_rdata_q <= 32'h0;
      err_q       <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
`ifdef IMEM_ARB_STARVE_GUARD_EN
      wait_cnt_q  <= 4'd0;
`endif
    end else begin
      if_valid_q  <= if_valid_d;
      if_instr_q  <= if_instr_d;
      dbg_valid_q <= dbg_valid_d;
      dbg_rdata_q <= dbg_rdata_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef IMEM_ARB_STARVE_GUARD_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.if_stall  = bus.if_req && !if_gnt;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.dbg_gnt   = dbg_gnt;
  assign bus.dbg_valid = dbg_valid_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.err       = err_q;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = mem_wdata_d;
  // No memory write may happen while reset is held.
  assign bus.mem_we    = dbg_gnt && bus.dbg_we && !bad && !reset;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed scenarios plus randomized traffic.
// Expected responses come from a queue-based reference model and a shadow memory.
module tb_imem_arbiter;
  localparam int MEM_WORDS = 2048;
  localparam int MAX_WAIT  = 4;
`ifdef IMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dbg_op_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fill = 1'b1;
  always #5 clk = ~clk;

  imem_arbiter_if bus ();

  imem_arbiter #(.MEM_WORDS(MEM_WORDS), .MAX_WAIT(MAX_WAIT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  function automatic logic [31:0] seed_word(int i);
    if (i == 2) return 32'h2002_0005;
    return (32'(i) * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  // Instruction memory seen by the DUT.
  logic [31:0] mem [MEM_WORDS];
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= seed_word(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[12:2]] <= bus.mem_wdata;
    end
  end
  assign bus.mem_rdata = mem[bus.mem_addr[12:2]];

  // Reference model state.
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] if_q[$];
  logic [31:0] dbg_q[$];
  logic [31:0] if_ops[$];
  dbg_op_t     dbg_ops[$];
  bit          if_pend, dbg_pend;
  logic [31:0] if_a;
  dbg_op_t     d_op;
  int          denied;
  bit          err_exp;
  logic [31:0] last_addr;
  logic [31:0] last_rd;
  bit          drop_en;
  bit          mon_en;
  bit          cnt_en, seen_if;
  int          dbg_before;
  int          stall_cnt;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_bad(logic [31:0] a);
    return ((a % 4) != 0) || ((longint'(a) / 4) >= MEM_WORDS);
  endfunction

  function automatic logic [31:0] rnd_addr();
    int unsigned k = $urandom_range(7);
    logic [31:0] w = 32'($urandom_range(MEM_WORDS - 1));
    if (k == 0) return (w << 2) | 32'($urandom_range(3, 1));
    if (k == 1) return (32'(MEM_WORDS) + 32'($urandom_range(4095))) << 2;
    return w << 2;
  endfunction

  // Monitor: every completion pops the oldest expected response.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.if_valid) begin
        if (if_q.size() == 0) chk("if_valid_unexpected", {31'h0, bus.if_valid}, 32'h0);
        else chk("if_instr", bus.if_instr, if_q.pop_front());
      end
      if (bus.dbg_valid) begin
        if (dbg_q.size() == 0) chk("dbg_valid_unexpected", {31'h0, bus.dbg_valid}, 32'h0);
        else chk("dbg_rdata", bus.dbg_rdata, dbg_q.pop_front());
      end
    end
  end

  // One cycle of stimulus plus model evaluation of the combinational outputs.
  task automatic do_cycle(input bit rst);
    bit          ireq, dreq, fetch_turn, eg_d, eg_i, gbad, exp_we;
    logic [31:0] ga, exp_addr, v;
    int          idx;
    @(negedge clk);
    chk("err", {31'h0, bus.err}, {31'h0, err_exp});
    if (!if_pend && if_ops.size() > 0) begin
      if_pend = 1'b1;
      if_a = if_ops.pop_front();
    end else if (if_pend && drop_en && $urandom_range(7) == 0) begin
      if_pend = 1'b0;
    end
    if (!dbg_pend && dbg_ops.size() > 0) begin
      dbg_pend = 1'b1;
      d_op = dbg_ops.pop_front();
    end
    reset         = rst;
    bus.if_req    = if_pend;
    bus.if_addr   = if_a;
    bus.dbg_req   = dbg_pend;
    bus.dbg_we    = d_op.we;
    bus.dbg_addr  = d_op.addr;
    bus.dbg_wdata = d_op.wdata;
    #1;
    ireq       = if_pend;
    dreq       = dbg_pend;
    fetch_turn = GUARD && (denied == MAX_WAIT);
    eg_d       = dreq && !(ireq && fetch_turn);
    eg_i       = ireq && !eg_d;
    ga         = eg_d ? d_op.addr : if_a;
    gbad       = (eg_d || eg_i) && is_bad(ga);
    exp_we     = eg_d && d_op.we && !gbad && !rst;
    exp_addr   = (eg_d || eg_i) ? (ga & ~32'h3) : last_addr;
    idx        = int'((ga / 4) % MEM_WORDS);

    chk("if_gnt", {31'h0, bus.if_gnt}, {31'h0, eg_i});
    chk("dbg_gnt", {31'h0, bus.dbg_gnt}, {31'h0, eg_d});
    chk("if_stall", {31'h0, bus.if_stall}, {31'h0, ireq && !eg_i});
    chk("mem_we", {31'h0, bus.mem_we}, {31'h0, exp_we});
    chk("mem_addr", bus.mem_addr, exp_addr);
    if (exp_we) chk("mem_wdata", bus.mem_wdata, d_op.wdata);

    if (cnt_en && !seen_if) begin
      if (bus.dbg_gnt) dbg_before++;
      if (bus.if_gnt) seen_if = 1'b1;
    end
    if (bus.if_stall) stall_cnt++;

    if (rst) begin
      if_q.delete();
      dbg_q.delete();
      err_exp   = 1'b0;
      denied    = 0;
      last_addr = 32'h0;
      last_rd   = 32'h0;
    end else begin
      if (eg_i) if_q.push_back(gbad ? 32'h0 : ref_mem[idx]);
      if (eg_d) begin
        if (d_op.we) begin
          if (!gbad) ref_mem[idx] = d_op.wdata;
          dbg_q.push_back(last_rd);
        end else begin
          v = gbad ? 32'h0 : ref_mem[idx];
          last_rd = v;
          dbg_q.push_back(v);
        end
      end
      err_exp   = err_exp || gbad;
      last_addr = exp_addr;
      // Consecutive-denial count for a waiting fetch.
      if (!ireq || eg_i) denied = 0;
      else if (denied < MAX_WAIT) denied++;
    end
    if (eg_i) if_pend = 1'b0;
    if (eg_d) dbg_pend = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((if_ops.size() > 0 || dbg_ops.size() > 0 || if_pend || dbg_pend) && n < 300) begin
      do_cycle(1'b0);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 32'(n), 32'h0);
    do_cycle(1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_if_valid"}, {31'h0, bus.if_valid}, 32'h0);
    chk({tag, "_dbg_valid"}, {31'h0, bus.dbg_valid}, 32'h0);
    chk({tag, "_err"}, {31'h0, bus.err}, 32'h0);
    chk({tag, "_mem_we"}, {31'h0, bus.mem_we}, 32'h0);
    chk({tag, "_if_instr"}, bus.if_instr, 32'h0);
    chk({tag, "_dbg_rdata"}, bus.dbg_rdata, 32'h0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
  endtask

  function automatic dbg_op_t mk_op(bit we, logic [31:0] addr, logic [31:0] wdata);
    dbg_op_t o;
    o.we = we;
    o.addr = addr;
    o.wdata = wdata;
    return o;
  endfunction

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = seed_word(i);
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h0; bus.dbg_wdata = 32'h0;
    if_pend = 1'b0; dbg_pend = 1'b0; if_a = 32'h0; d_op = mk_op(1'b0, 32'h0, 32'h0);
    denied = 0; err_exp = 1'b0; last_addr = 32'h0; last_rd = 32'h0;
    drop_en = 1'b0; cnt_en = 1'b0; seen_if = 1'b0; dbg_before = 0; stall_cnt = 0;
    mon_en = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
    fill = 1'b0;
    mon_en = 1'b1;

    // Fetch of word 2.
    if_ops.push_back(32'h8);
    drain();

    // Debug write then read-back of the same word in consecutive cycles.
    dbg_ops.push_back(mk_op(1'b1, 32'h10, 32'hDEAD_BEEF));
    dbg_ops.push_back(mk_op(1'b0, 32'h10, 32'h0));
    drain();

    // Sustained contention.
    for (int i = 0; i < 12; i++) dbg_ops.push_back(mk_op(1'b0, 32'(i) << 2, 32'h0));
    for (int i = 0; i < 4; i++) if_ops.push_back(32'h100 + (32'(i) << 2));
    cnt_en = 1'b1; seen_if = 1'b0; dbg_before = 0;
    drain();
    cnt_en = 1'b0;
    chk("contention_dbg_before_fetch", 32'(dbg_before), GUARD ? 32'(MAX_WAIT) : 32'd12);

    // Bad writes: misaligned and out of range.
    dbg_ops.push_back(mk_op(1'b1, 32'h13, 32'h1111_1111));
    dbg_ops.push_back(mk_op(1'b1, 32'h2000, 32'h2222_2222));
    drain();
    repeat (3) do_cycle(1'b0);
    chk("err_sticky", {31'h0, bus.err}, 32'h1);

    // Reset while a fetch is being granted.
    if_ops.push_back(32'h20);
    do_cycle(1'b1);
    @(negedge clk);
    reset = 1'b0;
    bus.if_req = 1'b0;
    bus.dbg_req = 1'b0;
    #1;
    check_reset_vals("midreset");

    // Fetch toggling without debug traffic never stalls.
    stall_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) if_ops.push_back(32'($urandom_range(MEM_WORDS - 1)) << 2);
      do_cycle(1'b0);
    end
    chk("toggle_no_stall", 32'(stall_cnt), 32'h0);

    // Randomized traffic.
    drop_en = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (if_ops.size() < 2 && $urandom_range(2) != 0) if_ops.push_back(rnd_addr());
      if (dbg_ops.size() < 2 && $urandom_range(2) == 0)
        dbg_ops.push_back(mk_op(1'($urandom_range(1)), rnd_addr(), $urandom));
      do_cycle(1'b0);
    end
    drop_en = 1'b0;
    drain();

    chk("if_queue_empty", 32'(if_q.size()), 32'h0);
    chk("dbg_queue_empty", 32'(dbg_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
